// File: rtl/mo_fetch.sv
// mo_fetch: per-line motion-object scanner.
//
// On hblank_start the block walks NUM_MO four-byte entries of the motion-object table
// at word address MO_BASE in working RAM. Each entry is read as two 16-bit words:
//   word 0: [7:0] picture code, [15:8] color/flags
//   word 1: [7:0] vertical position, [15:8] horizontal position
// An entry is on the next line when (vcount + 1 - vpos) mod 256 < 16. Up to MAX_HITS
// matching entries are handed to the renderer through a valid/ready port. A further
// match sets overflow and ends the scan early.
//
// Ports:
//   clk, reset, ce       clock, synchronous active-high reset, clock enable
//   hblank_start, vcount scan start pulse and current video line
//   ram_addr, ram_rd     working-RAM read port (ram_addr is used when ram_rd is high)
//   ram_q                RAM word, valid on the ce cycle after the address
//   mo_valid, mo_ready   descriptor handshake
//   mo_pic, mo_attr      picture code and color/flags
//   mo_row, mo_hpos      row within the 16-line object and horizontal position
//   scan_done, overflow  end-of-scan pulse and sticky too-many-objects flag
module mo_fetch #(
  parameter logic [10:0] MO_BASE  = 11'h480,
  parameter int unsigned NUM_MO   = 40,
  parameter int unsigned MAX_HITS = 8
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        ce,
  input  logic        hblank_start,
  input  logic [7:0]  vcount,
  output logic [10:0] ram_addr,
  output logic        ram_rd,
  input  logic [15:0] ram_q,
  output logic        mo_valid,
  input  logic        mo_ready,
  output logic [7:0]  mo_pic,
  output logic [7:0]  mo_attr,
  output logic [3:0]  mo_row,
  output logic [7:0]  mo_hpos,
  output logic        scan_done,
  output logic        overflow
);

  localparam int unsigned IdxW = (NUM_MO > 1) ? $clog2(NUM_MO) : 1;
  localparam int unsigned HitW = $clog2(MAX_HITS + 1);
  localparam logic [IdxW-1:0] LastIdx  = IdxW'(NUM_MO - 1);
  localparam logic [HitW-1:0] HitLimit = HitW'(MAX_HITS);

  typedef enum logic [2:0] {StIdle, StRd0, StRd1, StCap, StPush, StDone} state_e;

  state_e          state_q;
  logic [IdxW-1:0] idx_q;
  logic [HitW-1:0] hits_q;
  logic [7:0]      target_q;
  logic [10:0]     obj_base_q;  // MO_BASE + 2 * idx_q, kept incrementally

  logic [7:0] diff;
  logic       hit;
  logic       advance;
  logic       last_obj;

  // In StCap ram_q carries word 1 of the current entry (vpos / hpos).
  assign diff     = target_q - ram_q[7:0];
  assign hit      = (diff[7:4] == 4'd0);
  assign last_obj = (idx_q == LastIdx);
  // Current entry is finished: either it missed or its descriptor was taken.
  assign advance  = ((state_q == StCap) && !hit) || ((state_q == StPush) && mo_ready);

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= StIdle;
      idx_q      <= '0;
      hits_q     <= '0;
      target_q   <= '0;
      obj_base_q <= '0;
      ram_addr   <= '0;
      ram_rd     <= 1'b0;
      mo_valid   <= 1'b0;
      mo_pic     <= '0;
      mo_attr    <= '0;
      mo_row     <= '0;
      mo_hpos    <= '0;
      scan_done  <= 1'b0;
      overflow   <= 1'b0;
    end else if (ce) begin
      scan_done <= 1'b0;
      if (hblank_start) begin
        // Start, or abort and restart, a scan for the next line.
        state_q    <= StRd0;
        idx_q      <= '0;
        hits_q     <= '0;
        overflow   <= 1'b0;
        target_q   <= vcount + 8'd1;
        obj_base_q <= MO_BASE;
        ram_addr   <= MO_BASE;
        ram_rd     <= 1'b1;
        mo_valid   <= 1'b0;
      end else begin
        unique case (state_q)
          StIdle: ;
          StRd0: begin
            ram_addr <= ram_addr + 11'd1;
            state_q  <= StRd1;
          end
          StRd1: begin
            mo_pic  <= ram_q[7:0];
            mo_attr <= ram_q[15:8];
            ram_rd  <= 1'b0;
            state_q <= StCap;
          end
          StCap: begin
            if (hit) begin
              if (hits_q == HitLimit) begin
                overflow  <= 1'b1;
                scan_done <= 1'b1;
                state_q   <= StDone;
              end else begin
                mo_row   <= diff[3:0];
                mo_hpos  <= ram_q[15:8];
                mo_valid <= 1'b1;
                state_q  <= StPush;
              end
            end
          end
          StPush: begin
            if (mo_ready) begin
              mo_valid <= 1'b0;
              hits_q   <= hits_q + HitW'(1);
            end
          end
          StDone:  state_q <= StIdle;
          default: state_q <= StIdle;
        endcase

        if (advance) begin
          if (last_obj) begin
            scan_done <= 1'b1;
            state_q   <= StDone;
          end else begin
            idx_q      <= idx_q + IdxW'(1);
            obj_base_q <= obj_base_q + 11'd2;
            ram_addr   <= obj_base_q + 11'd2;
            ram_rd     <= 1'b1;
            state_q    <= StRd0;
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_mo_fetch.sv
module tb_mo_fetch;

  localparam logic [10:0] MO_BASE  = 11'h480;
  localparam int unsigned NUM_MO   = 40;
  localparam int unsigned MAX_HITS = 8;

  logic        clk = 1'b0;
  logic        reset, ce, hblank_start, mo_ready;
  logic [7:0]  vcount;
  logic [10:0] ram_addr;
  logic        ram_rd, mo_valid, scan_done, overflow;
  logic [15:0] ram_q;
  logic [7:0]  mo_pic, mo_attr, mo_hpos;
  logic [3:0]  mo_row;

  always #5 clk = ~clk;

  mo_fetch #(
    .MO_BASE  (MO_BASE),
    .NUM_MO   (NUM_MO),
    .MAX_HITS (MAX_HITS)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .ce           (ce),
    .hblank_start (hblank_start),
    .vcount       (vcount),
    .ram_addr     (ram_addr),
    .ram_rd       (ram_rd),
    .ram_q        (ram_q),
    .mo_valid     (mo_valid),
    .mo_ready     (mo_ready),
    .mo_pic       (mo_pic),
    .mo_attr      (mo_attr),
    .mo_row       (mo_row),
    .mo_hpos      (mo_hpos),
    .scan_done    (scan_done),
    .overflow     (overflow)
  );

  typedef struct packed {
    logic [7:0] pic;
    logic [7:0] attr;
    logic [3:0] row;
    logic [7:0] hpos;
  } desc_t;

  logic [15:0] mem [2048];
  desc_t       exp_q [$];
  logic        exp_ovf;
  desc_t       last_acc;
  int          n_acc, n_valid_cyc;
  int          n_checks = 0;
  int          n_pass   = 0;
  int          ncyc;
  logic        model_on = 1'b0;
  logic        ce_mode  = 1'b0;
  logic        ready_def = 1'b1;
  int          stall_left = 0;
  logic        saw_lo, saw_hi;
  logic        prev_valid = 1'b0;
  logic [10:0] prev_addr = '0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act === req) n_pass++;
    else $display("FAIL %s: actual %0h required %0h at %0t", name, act, req, $time);
  endtask

  // Working RAM: registered read, data on the ce cycle after the address.
  always @(posedge clk) begin
    if (ce && ram_rd) begin
      ram_q <= mem[ram_addr];
      if (ram_addr == MO_BASE + 11'd6) saw_lo <= 1'b1;
      if (ram_addr == MO_BASE + 11'd7) saw_hi <= 1'b1;
    end
  end

  task automatic set_obj(input int i, input logic [7:0] vpos);
    int a;
    logic [7:0] ii;
    ii = 8'(i);
    a = (int'(MO_BASE) + 2 * i) % 2048;
    mem[a] = {ii ^ 8'h5A, ii + 8'h10};
    mem[(a + 1) % 2048] = {ii * 8'd3 + 8'd7, vpos};
  endtask

  task automatic clear_table();
    for (int a = 0; a < 2048; a++) mem[a] = 16'hDEAD ^ 16'(a);
    for (int i = 0; i < int'(NUM_MO); i++) set_obj(i, 8'hF0);
  endtask

  // Reference: list of descriptors a scan for line vc+1 must deliver.
  task automatic build_expect(input logic [7:0] vc);
    logic [7:0]  target, d;
    logic [15:0] w0, w1;
    int hits, a;
    target = vc + 8'd1;
    exp_q.delete();
    exp_ovf = 1'b0;
    hits = 0;
    for (int i = 0; i < int'(NUM_MO); i++) begin
      a  = (int'(MO_BASE) + 2 * i) % 2048;
      w0 = mem[a];
      w1 = mem[(a + 1) % 2048];
      d  = target - w1[7:0];
      if (d < 8'd16) begin
        if (hits == int'(MAX_HITS)) begin
          exp_ovf = 1'b1;
          break;
        end
        exp_q.push_back('{pic: w0[7:0], attr: w0[15:8], row: d[3:0], hpos: w1[15:8]});
        hits++;
      end
    end
  endtask

  always @(negedge clk) begin
    if (model_on && !reset) begin
      if (mo_valid) begin
        n_valid_cyc++;
        chk("rd_in_push", {31'd0, ram_rd}, 32'd0);
        if (prev_valid) chk("addr_hold", {21'd0, ram_addr}, {21'd0, prev_addr});
        if (exp_q.size() == 0) begin
          chk("unexpected_valid", {31'd0, mo_valid}, 32'd0);
        end else begin
          chk("descriptor", {4'd0, mo_pic, mo_attr, mo_row, mo_hpos}, {4'd0, exp_q[0]});
          if (ce && mo_ready) begin
            last_acc = exp_q.pop_front();
            n_acc++;
          end
        end
      end
      if (scan_done && ce) begin
        chk("done_all_delivered", exp_q.size(), 32'd0);
        chk("done_overflow", {31'd0, overflow}, {31'd0, exp_ovf});
      end
    end
    prev_valid = mo_valid;
    prev_addr  = ram_addr;
  end

  task automatic step();
    if (ce) ncyc++;
    @(posedge clk);
    #1;
    ce = ce_mode ? ~ce : 1'b1;
    if (mo_valid && stall_left > 0) begin
      mo_ready = 1'b0;
      stall_left--;
    end else begin
      mo_ready = ready_def;
    end
  endtask

  task automatic check_zero(input string tag);
    chk({tag, "_valid"}, {31'd0, mo_valid}, 32'd0);
    chk({tag, "_rd"}, {31'd0, ram_rd}, 32'd0);
    chk({tag, "_done"}, {31'd0, scan_done}, 32'd0);
    chk({tag, "_ovf"}, {31'd0, overflow}, 32'd0);
    chk({tag, "_addr"}, {21'd0, ram_addr}, 32'd0);
    chk({tag, "_desc"}, {4'd0, mo_pic, mo_attr, mo_row, mo_hpos}, 32'd0);
  endtask

  // Scan for line vc+1; lat = ce cycles from the hblank_start cycle to scan_done.
  task automatic run_scan(input logic [7:0] vc, output int lat);
    int guard, c0;
    n_acc = 0;
    n_valid_cyc = 0;
    vcount = vc;
    while (!ce) step();
    hblank_start = 1'b1;
    ncyc = 0;
    step();
    hblank_start = 1'b0;
    guard = 0;
    while (!scan_done && guard < 3000) begin
      step();
      guard++;
    end
    lat = ncyc;
    chk("scan_done_seen", {31'd0, scan_done}, 32'd1);
    c0 = ncyc;
    while (ncyc == c0) step();
    chk("scan_done_pulse", {31'd0, scan_done}, 32'd0);
  endtask

  initial begin
    int lat, guard;
    logic any;
    reset = 1'b1;
    ce = 1'b0;
    hblank_start = 1'b0;
    vcount = '0;
    mo_ready = 1'b0;
    saw_lo = 1'b0;
    saw_hi = 1'b0;
    clear_table();

    // Reset takes effect with ce low.
    repeat (3) @(posedge clk);
    #1;
    check_zero("reset");
    reset = 1'b0;
    any = 1'b0;
    repeat (5) begin
      step();
      any |= ram_rd | scan_done | mo_valid;
    end
    chk("idle_quiet", {31'd0, any}, 32'd0);

    // Empty table.
    model_on = 1'b1;
    build_expect(8'd10);
    chk("model_empty", exp_q.size(), 32'd0);
    run_scan(8'd10, lat);
    chk("empty_latency", lat, 32'd121);
    chk("empty_no_valid", n_valid_cyc, 32'd0);
    chk("empty_ovf", {31'd0, overflow}, 32'd0);

    // One object, row 5, read at MO_BASE+6/+7.
    clear_table();
    set_obj(3, 8'd20);
    build_expect(8'd24);
    chk("model_one", exp_q.size(), 32'd1);
    chk("model_row5", {28'd0, exp_q[0].row}, 32'd5);
    saw_lo = 1'b0;
    saw_hi = 1'b0;
    run_scan(8'd24, lat);
    chk("one_latency", lat, 32'd122);
    chk("one_count", n_acc, 32'd1);
    chk("one_row", {28'd0, last_acc.row}, 32'd5);
    chk("one_pic", {24'd0, last_acc.pic}, 32'h13);
    chk("read_base6", {31'd0, saw_lo}, 32'd1);
    chk("read_base7", {31'd0, saw_hi}, 32'd1);

    // Ten matches: eight delivered, then overflow.
    clear_table();
    for (int i = 0; i < 10; i++) set_obj(i, 8'd100);
    build_expect(8'd100);
    chk("model_eight", exp_q.size(), 32'd8);
    chk("model_ovf", {31'd0, exp_ovf}, 32'd1);
    run_scan(8'd100, lat);
    chk("ovf_latency", lat, 32'd36);
    chk("ovf_count", n_acc, 32'd8);
    chk("ovf_row", {28'd0, last_acc.row}, 32'd1);
    chk("ovf_flag", {31'd0, overflow}, 32'd1);

    // Line wrap; overflow cleared by the new scan.
    clear_table();
    set_obj(0, 8'hFA);
    build_expect(8'h02);
    chk("model_row9", {28'd0, exp_q[0].row}, 32'd9);
    run_scan(8'h02, lat);
    chk("wrap_count", n_acc, 32'd1);
    chk("wrap_row", {28'd0, last_acc.row}, 32'd9);
    chk("wrap_ovf_clear", {31'd0, overflow}, 32'd0);

    // Renderer stalls five cycles.
    clear_table();
    set_obj(5, 8'd50);
    build_expect(8'd49);
    stall_left = 5;
    run_scan(8'd49, lat);
    chk("stall_latency", lat, 32'd127);
    chk("stall_valid_cycles", n_valid_cyc, 32'd6);
    chk("stall_count", n_acc, 32'd1);
    chk("stall_hpos", {24'd0, last_acc.hpos}, 32'd22);

    // Clock enable low every other cycle.
    clear_table();
    set_obj(3, 8'd20);
    build_expect(8'd24);
    ce_mode = 1'b1;
    run_scan(8'd24, lat);
    ce_mode = 1'b0;
    step();
    chk("ce_latency", lat, 32'd122);
    chk("ce_count", n_acc, 32'd1);

    // Abort during PUSH, then reset during RD1.
    clear_table();
    set_obj(0, 8'd31);
    model_on = 1'b0;
    ready_def = 1'b0;
    vcount = 8'd30;
    hblank_start = 1'b1;
    step();
    hblank_start = 1'b0;
    guard = 0;
    while (!mo_valid && guard < 200) begin
      step();
      guard++;
    end
    chk("abort_push_reached", {31'd0, mo_valid}, 32'd1);
    hblank_start = 1'b1;
    step();
    hblank_start = 1'b0;
    chk("abort_valid_drop", {31'd0, mo_valid}, 32'd0);
    chk("abort_restart_rd", {31'd0, ram_rd}, 32'd1);
    chk("abort_restart_addr", {21'd0, ram_addr}, {21'd0, MO_BASE});
    step();
    chk("abort_rd1_addr", {21'd0, ram_addr}, {21'd0, MO_BASE + 11'd1});
    reset = 1'b1;
    step();
    reset = 1'b0;
    check_zero("midreset");
    any = 1'b0;
    repeat (8) begin
      step();
      any |= ram_rd | scan_done | mo_valid;
    end
    chk("midreset_idle", {31'd0, any}, 32'd0);

    // Clean scan after reset.
    ready_def = 1'b1;
    step();
    model_on = 1'b1;
    build_expect(8'd30);
    run_scan(8'd30, lat);
    chk("clean_latency", lat, 32'd122);
    chk("clean_count", n_acc, 32'd1);
    chk("clean_row", {28'd0, last_acc.row}, 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
